decode_stage: RTL
=================

# decode_stage

Decode/operand stage that sits directly upstream of `alu`. It accepts 32-bit RV32I instruction words from fetch over a valid/ready handshake and decodes the register-register (OP) and register-immediate (OP-IMM) ALU instructions. It reads operands from an internal 32×32 register file and presents `a`, `b` and `alu_op` to the ALU from a single-entry output register. It also owns the register-file write port, which writeback drives.

## Interface
- `DATA_WIDTH`, 32: operand and register width.
- `REG_COUNT`, 32: number of architectural registers; x0 is hardwired to zero.
- `clk` input 1: sole clock; everything updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_valid` input 1: fetch presents an instruction.
- `in_instr` input 32: instruction word.
- `in_ready` output 1: stage can accept; equals `!out_valid || out_ready`.
- `out_valid` output 1: output register holds a decoded instruction.
- `out_ready` input 1: execute consumes the output.
- `out_a` output DATA_WIDTH: operand A, rs1 value.
- `out_b` output DATA_WIDTH: operand B, rs2 value or sign-extended immediate.
- `out_alu_op` output 3: ALU opcode from the shared package.
- `out_rd` output 5: destination register index.
- `out_illegal` output 1: instruction is not in the supported subset.
- `flush` input 1: discard the held output and any same-cycle accept.
- `wb_en` input 1: register write enable.
- `wb_rd` input 5: write index.
- `wb_data` input DATA_WIDTH: write data.

## Operation
- Supported opcodes:
  - OP (0110011).
  - OP-IMM (0010011).
- Supported operations: ADD/ADDI, SUB, AND/ANDI, OR/ORI, XOR/XORI, SLT/SLTI, SLL/SLLI, SRL/SRLI. These map to `ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`, `ALU_XOR`, `ALU_SLT`, `ALU_SLL`, `ALU_SRL`.
- Decoding checks the whole relevant instruction field, not partial bits:
  - SUB requires funct7 0100000.
  - Every other OP instruction requires funct7 0000000.
  - SLLI and SRLI require imm[11:5] = 0000000.
  - SRA, SRAI, SLTU, SLTIU and any other opcode are illegal.
- Illegal instructions still produce a beat: `out_illegal`=1, `out_alu_op`=`ALU_ADD`, `out_a`=0, `out_b`=0, `out_rd`=0. Trap handling happens downstream.
- I-type immediates are instr[31:20], sign-extended to DATA_WIDTH. Shift immediates use instr[24:20], zero-extended.
- Register file:
  - Two combinational read ports and one write port.
  - Writes to x0 are ignored; x0 always reads 0.
  - Write-through bypass: if `wb_en` is set and `wb_rd` matches rs1 or rs2 (nonzero) in the accept cycle, the stage captures `wb_data`.
- Operands are sampled only at accept. A held output is not updated by later writebacks. RAW hazard avoidance beyond the same-cycle bypass belongs to the issue scoreboard, not this block.
- Output register states:
  - EMPTY (`out_valid`=0).
  - FULL (`out_valid`=1).
- Output register transitions:
  - EMPTY → FULL on accept.
  - FULL → FULL on consume with a simultaneous accept (new beat replaces the old one).
  - FULL → EMPTY on consume without accept.
  - FULL → FULL, holding, while `out_ready`=0.
- Accept is `in_valid && in_ready && !flush`.
- `flush` forces `out_valid` to 0 next cycle and blocks accept that cycle. Writebacks during `flush` still commit.
- While FULL and stalled, all `out_*` outputs are stable.

## Timing
- Latency: an instruction accepted at edge N appears on `out_*` after edge N, one cycle.
- Throughput: one instruction per cycle while `out_ready`=1.
- `in_ready` is combinational from `out_valid` and `out_ready` only. It never depends on `in_valid`.
- Register write commits at the edge where `wb_en`=1. The value is readable combinationally from the next cycle, and via bypass in the same cycle.
- Reset, applied at any edge including mid-stall:
  - `out_valid`=0 and all `out_*` outputs are 0.
  - All registers x1–x31 become 0.
  - `in_ready`=1 from the first cycle after reset.
  - `wb_en` is ignored during reset.

## Structure
- `isa_shared` package holds:
  - The ALU opcode enum (3 bits).
  - Opcode constants `OPC_OP` and `OPC_OP_IMM`.
  - funct3/funct7 constants.
  - Register index width.
- Sub-module `regfile`: parameterised `REG_COUNT`×`DATA_WIDTH`, two read ports, one write port, synchronous reset, x0 hardwired. The bypass lives in `decode_stage`.
- Decode is one combinational block feeding the output register.

## Test plan
- Reset, then write x1=5 and x2=7. Issue `add x3,x1,x2` (0x002081B3) with `out_ready`=1. Next cycle expect `out_a`=5, `out_b`=7, `out_alu_op`=`ALU_ADD`, `out_rd`=3, `out_illegal`=0.
- Issue `addi x4,x1,-1` (0xFFF08213). Expect `out_b`=0xFFFFFFFF and `out_alu_op`=`ALU_ADD`. Also issue `sub` (funct7 0100000) and expect `ALU_SUB`.
- Hold `out_ready`=0 with a back-to-back stream. Expect `in_ready`=0 after the first accept and `out_*` stable for 5 cycles. Release `out_ready`: the next instruction appears one cycle later, with no loss or duplication.
- Same-cycle bypass: `wb_en`=1, `wb_rd`=1, `wb_data`=0xDEAD while accepting `add x3,x1,x0`. Expect `out_a`=0xDEAD. Write x0=9 and read x0: expect 0.
- Illegal cases: SRA (funct7 0100000, funct3 101) and opcode 0000011. Expect `out_illegal`=1 and `out_a`=`out_b`=`out_rd`=0.
- `flush` while FULL and with `in_valid`=1 → `out_valid`=0 next cycle and the instruction is not accepted. Asserting `rst` mid-stall → `out_valid`=0 and x1 reads 0.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode constants and the ALU opcode encoding used by decode and execute.
package isa_shared;

    localparam int REG_IDX_W = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5,
        ALU_SLL = 3'd6,
        ALU_SRL = 3'd7
    } alu_op_t;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side handshake, execute-side output beat, flush and writeback port of the decode stage.
interface decode_stage_if
    import isa_shared::*;
#(
    parameter int DATA_WIDTH = 32
) ();

    logic                  in_valid;
    logic [31:0]           in_instr;
    logic                  in_ready;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_a;
    logic [DATA_WIDTH-1:0] out_b;
    alu_op_t               out_alu_op;
    logic [REG_IDX_W-1:0]  out_rd;
    logic                  out_illegal;

    logic                  flush;

    logic                  wb_en;
    logic [REG_IDX_W-1:0]  wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;

    modport master (
        output in_valid, in_instr, out_ready, flush, wb_en, wb_rd, wb_data,
        input  in_ready, out_valid, out_a, out_b, out_alu_op, out_rd, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, out_ready, flush, wb_en, wb_rd, wb_data,
        output in_ready, out_valid, out_a, out_b, out_alu_op, out_rd, out_illegal
    );

endinterface

// File: rtl/decode_stage_regfile.sv
// Architectural register file: two combinational reads, one write, x0 hardwired to zero.
module regfile
    import isa_shared::*;
#(
    parameter int REG_COUNT  = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_IDX_W-1:0]  ra1,
    input  logic [REG_IDX_W-1:0]  ra2,
    output logic [DATA_WIDTH-1:0] rd1,
    output logic [DATA_WIDTH-1:0] rd2,
    input  logic                  we,
    input  logic [REG_IDX_W-1:0]  wa,
    input  logic [DATA_WIDTH-1:0] wd
);

    logic [DATA_WIDTH-1:0] mem [REG_COUNT];

    // Clear everything on reset; otherwise commit writes to any register but x0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            mem[wa] <= wd;
        end
    end

    // Read ports; x0 is forced to zero regardless of storage contents.
    always_comb begin
        rd1 = (ra1 == '0) ? '0 : mem[ra1];
        rd2 = (ra2 == '0) ? '0 : mem[ra2];
    end

endmodule

// File: rtl/decode_stage.sv
// Decode/operand stage for OP and OP-IMM instructions with a single-entry output register.
//
// state     | meaning
// ----------+----------------------------------------------
// OUT_EMPTY | no beat held, out_valid=0
// OUT_FULL  | decoded beat held for execute, out_valid=1
module decode_stage
    import isa_shared::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
);

    out_state_t state_q, state_d;
    logic       accept;

    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic [REG_IDX_W-1:0] rs1, rs2, rd;
    logic [DATA_WIDTH-1:0] rf_rd1, rf_rd2, rs1_val, rs2_val;
    logic [DATA_WIDTH-1:0] imm_i, imm_sh;

    logic                  dec_legal;
    alu_op_t               dec_op;
    logic                  dec_use_imm;
    logic                  dec_shift_imm;
    logic [DATA_WIDTH-1:0] dec_a, dec_b;
    logic [REG_IDX_W-1:0]  dec_rd;

    logic [DATA_WIDTH-1:0] a_q, b_q;
    alu_op_t               op_q;
    logic [REG_IDX_W-1:0]  rd_q;
    logic                  ill_q;

    assign opcode = bus.in_instr[6:0];
    assign rd     = bus.in_instr[11:7];
    assign funct3 = bus.in_instr[14:12];
    assign rs1    = bus.in_instr[19:15];
    assign rs2    = bus.in_instr[24:20];
    assign funct7 = bus.in_instr[31:25];
    assign imm_i  = {{(DATA_WIDTH-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
    assign imm_sh = {{(DATA_WIDTH-5){1'b0}}, bus.in_instr[24:20]};

    regfile #(.REG_COUNT(REG_COUNT), .DATA_WIDTH(DATA_WIDTH)) u_regfile (
        .clk (clk),
        .rst (rst),
        .ra1 (rs1),
        .ra2 (rs2),
        .rd1 (rf_rd1),
        .rd2 (rf_rd2),
        .we  (bus.wb_en),
        .wa  (bus.wb_rd),
        .wd  (bus.wb_data)
    );

    // Same-cycle writeback bypass so an accept never sees a stale operand being written now.
    always_comb begin
        rs1_val = (bus.wb_en && (bus.wb_rd == rs1) && (rs1 != '0)) ? bus.wb_data : rf_rd1;
        rs2_val = (bus.wb_en && (bus.wb_rd == rs2) && (rs2 != '0)) ? bus.wb_data : rf_rd2;
    end

    // Full-field decode of the supported subset; anything else becomes a zeroed illegal beat.
    always_comb begin
        dec_legal     = 1'b0;
        dec_op        = ALU_ADD;
        dec_use_imm   = 1'b0;
        dec_shift_imm = 1'b0;
        if (opcode == OPC_OP) begin
            case (funct3)
                F3_ADD_SUB: begin
                    if (funct7 == F7_BASE) begin
                        dec_legal = 1'b1; dec_op = ALU_ADD;
                    end else if (funct7 == F7_ALT) begin
                        dec_legal = 1'b1; dec_op = ALU_SUB;
                    end
                end
                F3_SLL:     begin dec_legal = (funct7 == F7_BASE); dec_op = ALU_SLL; end
                F3_SLT:     begin dec_legal = (funct7 == F7_BASE); dec_op = ALU_SLT; end
                F3_XOR:     begin dec_legal = (funct7 == F7_BASE); dec_op = ALU_XOR; end
                F3_SRL_SRA: begin dec_legal = (funct7 == F7_BASE); dec_op = ALU_SRL; end
                F3_OR:      begin dec_legal = (funct7 == F7_BASE); dec_op = ALU_OR;  end
                F3_AND:     begin dec_legal = (funct7 == F7_BASE); dec_op = ALU_AND; end
                default:    dec_legal = 1'b0;
            endcase
        end else if (opcode == OPC_OP_IMM) begin
            dec_use_imm = 1'b1;
            case (funct3)
                F3_ADD_SUB: begin dec_legal = 1'b1; dec_op = ALU_ADD; end
                F3_SLL:     begin dec_legal = (funct7 == F7_BASE); dec_op = ALU_SLL; dec_shift_imm = 1'b1; end
                F3_SLT:     begin dec_legal = 1'b1; dec_op = ALU_SLT; end
                F3_XOR:     begin dec_legal = 1'b1; dec_op = ALU_XOR; end
                F3_SRL_SRA: begin dec_legal = (funct7 == F7_BASE); dec_op = ALU_SRL; dec_shift_imm = 1'b1; end
                F3_OR:      begin dec_legal = 1'b1; dec_op = ALU_OR;  end
                F3_AND:     begin dec_legal = 1'b1; dec_op = ALU_AND; end
                default:    dec_legal = 1'b0;
            endcase
        end

        if (dec_legal) begin
            dec_a  = rs1_val;
            dec_b  = !dec_use_imm ? rs2_val : (dec_shift_imm ? imm_sh : imm_i);
            dec_rd = rd;
        end else begin
            dec_op = ALU_ADD;
            dec_a  = '0;
            dec_b  = '0;
            dec_rd = '0;
        end
    end

    assign bus.in_ready  = (state_q == OUT_EMPTY) || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready && !bus.flush;

    // Output register occupancy state.
    always_ff @(posedge clk) begin
        if (rst) state_q <= OUT_EMPTY;
        else     state_q <= state_d;
    end

    // Next occupancy: flush wins, then accept refills, then a consume drains.
    always_comb begin
        state_d = state_q;
        if (bus.flush)                                  state_d = OUT_EMPTY;
        else if (accept)                                state_d = OUT_FULL;
        else if ((state_q == OUT_FULL) && bus.out_ready) state_d = OUT_EMPTY;
    end

    // Beat payload is captured only at accept, so stalled outputs stay frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= ALU_ADD;
            rd_q  <= '0;
            ill_q <= 1'b0;
        end else if (accept) begin
            a_q   <= dec_a;
            b_q   <= dec_b;
            op_q  <= dec_op;
            rd_q  <= dec_rd;
            ill_q <= !dec_legal;
        end
    end

    assign bus.out_valid   = (state_q == OUT_FULL);
    assign bus.out_a       = a_q;
    assign bus.out_b       = b_q;
    assign bus.out_alu_op  = op_q;
    assign bus.out_rd      = rd_q;
    assign bus.out_illegal = ill_q;

endmodule
